experiment1_nios2_qsys_0_ocimem_arbiter: RTL and testbench
==========================================================

# experiment1_nios2_qsys_0_ocimem_arbiter

Sysclk-domain arbiter sharing the Nios II on-chip debug memory (single-port OCI RAM, 1-cycle read latency) between two requesters:
- the JTAG debug path, as single-cycle command strobes already synchronised into `clk`;
- the CPU's Avalon debug slave.

It sequences each access through a small FSM, auto-increments the JTAG address, returns read data to `MonDReg` or `avs_readdata`, and flags dropped JTAG commands.

## Interface
Parameters:
- `ADDR_W`, 8, OCI RAM address width; address wraps modulo 2^ADDR_W
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `jtag_addr_load`  in  1  pulse: load `jtag_addr` into JTAG address pointer
- `jtag_addr`  in  ADDR_W  address to load
- `jtag_rd`  in  1  pulse: read RAM at pointer into `MonDReg`, then increment
- `jtag_wr`  in  1  pulse: write `jtag_wdata` at pointer, then increment
- `jtag_wdata`  in  DATA_W  JTAG write data, sampled with `jtag_wr`
- `MonDReg`  out  DATA_W  last JTAG read result
- `jtag_busy`  out  1  JTAG command pending or in flight
- `jtag_overrun`  out  1  sticky: a JTAG strobe was dropped
- `avs_address`  in  ADDR_W  CPU address
- `avs_read`  in  1  CPU read request, held until waitrequest low
- `avs_write`  in  1  CPU write request, held until waitrequest low
- `avs_writedata`  in  DATA_W  CPU write data
- `avs_readdata`  out  DATA_W  CPU read data, valid when waitrequest low
- `avs_waitrequest`  out  1  combinational stall
- `ram_en`  out  1  RAM access strobe
- `ram_wren`  out  1  RAM write enable, qualified by `ram_en`
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after `ram_en` with `ram_wren=0`

## Operation
- **JTAG capture.**
  - Strobes accepted while `jtag_busy=0` latch a one-deep pending command (op, data) and raise `jtag_busy` the next cycle.
  - `jtag_addr_load` accepted while idle loads the pointer and clears `jtag_overrun`.
  - If `jtag_addr_load` and `jtag_rd`/`jtag_wr` arrive in the same cycle, the command uses the newly loaded address.
  - `jtag_rd` and `jtag_wr` together: write executes, read is dropped, `jtag_overrun` set.
  - Any strobe while `jtag_busy=1` is dropped and sets `jtag_overrun`; pointer and pending command are unchanged.
- **FSM states:**
  - `IDLE`: select requester, register `ram_addr`/`ram_wdata`/`ram_wren`, then go to `ACC`.
  - `ACC`: `ram_en=1`. Write → `IDLE` with completion. Read → `RDWAIT`.
  - `RDWAIT`: capture `ram_rdata` into `MonDReg` or `avs_readdata` at the clock edge, then → `IDLE` with completion.
- **Arbitration.**
  - Round-robin on a `last_grant` bit, reset value CPU, so JTAG wins the first tie.
  - A lone requester is always granted.
  - CPU request is `avs_read|avs_write` masked by `cpu_done`. `avs_write` has priority if both are high.
- **Completion.**
  - JTAG: pointer increments modulo 2^ADDR_W; `jtag_busy` falls the next cycle.
  - CPU: `cpu_done` register pulses high for exactly one cycle.
- `avs_waitrequest = (avs_read|avs_write) & ~cpu_done`.
- `ram_en`/`ram_wren` are high only in `ACC`; low otherwise.

## Timing
- Reset values:
  - all outputs 0: `MonDReg`, `avs_readdata`, `jtag_busy`, `jtag_overrun`, `ram_en`, `ram_wren`, `ram_addr`, `ram_wdata`;
  - pointer 0, FSM `IDLE`, `last_grant`=CPU, no pending command;
  - `avs_waitrequest` follows its equation, so it is high after reset if a request is held.
- JTAG latency, strobe in cycle 0: pending set in cycle 1, `ACC` in cycle 2.
  - Write: `jtag_busy` low in cycle 3.
  - Read: `RDWAIT` in cycle 3; `MonDReg` updated and `jtag_busy` low in cycle 4.
- CPU latency, request first seen in cycle 0 with FSM idle: `ACC` in cycle 1.
  - Write: waitrequest low in cycle 2.
  - Read: waitrequest low with `avs_readdata` valid in cycle 3.
- Contention adds the full length of the other requester's access.
- Reset mid-access aborts the access: pending JTAG command lost, no increment, no capture, RAM contents untouched. If reset is released while the CPU request is held, the access restarts cleanly.
- Throughput: at most one RAM access per 2 cycles (write) or 3 cycles (read).

## Test plan
- **JTAG write/read:** `jtag_addr_load` addr=0x10; `jtag_wr` 0xDEADBEEF; `jtag_addr_load` 0x10; `jtag_rd` → RAM[0x10]=0xDEADBEEF; `MonDReg`=0xDEADBEEF 4 cycles after `jtag_rd`; pointer=0x11.
- **Wrap:** load 0xFF; `jtag_wr` twice (A, B) → RAM[0xFF]=A, RAM[0x00]=B, pointer=0x01.
- **CPU access:** `avs_write` addr 0x20 data 0x12345678 → waitrequest low exactly 2 cycles later. `avs_read` 0x20 → `avs_readdata`=0x12345678 with waitrequest low in cycle 3.
- **Simultaneous requests:** JTAG read and CPU write pending in the same idle cycle, after reset → JTAG served first, then CPU. Repeat the tie → CPU served first.
- **Overrun:** `jtag_rd`, then `jtag_wr` 1 cycle later → second strobe dropped, RAM unchanged, `jtag_overrun`=1 until the next accepted `jtag_addr_load`.
- **Mid-access reset:** assert `reset` while FSM is in `ACC` for a JTAG read → `jtag_busy`=0, `MonDReg`=0, pointer=0 the next cycle; held CPU read completes normally after release.

Source files
------------

// File: rtl/experiment1_nios2_qsys_0_ocimem_arbiter.sv
// Arbiter sharing the single-port OCI debug RAM between the JTAG command path
// and the CPU Avalon debug slave. Each access runs IDLE -> ACC [-> RDWAIT].
module experiment1_nios2_qsys_0_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_rd,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic              ram_en,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACC    = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;

    localparam logic OWN_JTAG = 1'b0;
    localparam logic OWN_CPU  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              jpend_q, jpend_d;
    logic              jpend_wr_q, jpend_wr_d;
    logic [DATA_W-1:0] jpend_data_q, jpend_data_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic              cpu_done_q, cpu_done_d;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic cpu_req;
    logic complete;

    assign cpu_req = (avs_read | avs_write) & ~cpu_done_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        jpend_d      = jpend_q;
        jpend_wr_d   = jpend_wr_q;
        jpend_data_d = jpend_data_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wren_d       = wren_q;
        cpu_done_d   = 1'b0;
        mon_d        = mon_q;
        rdata_d      = rdata_q;
        complete     = 1'b0;

        // JTAG strobes: a pointer load lands in the same edge as the command
        // latch, so a combined load+command uses the new address.
        if (!busy_q) begin
            if (jtag_addr_load) begin
                ptr_d     = jtag_addr;
                overrun_d = 1'b0;
            end
            if (jtag_rd | jtag_wr) begin
                jpend_d      = 1'b1;
                busy_d       = 1'b1;
                jpend_wr_d   = jtag_wr;
                jpend_data_d = jtag_wdata;
            end
            if (jtag_rd & jtag_wr) begin
                overrun_d = 1'b1;
            end
        end else if (jtag_addr_load | jtag_rd | jtag_wr) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (jpend_q && (!cpu_req || last_grant_q == OWN_CPU)) begin
                    owner_d      = OWN_JTAG;
                    last_grant_d = OWN_JTAG;
                    addr_d       = ptr_q;
                    wdata_d      = jpend_data_q;
                    wren_d       = jpend_wr_q;
                    jpend_d      = 1'b0;
                    state_d      = S_ACC;
                end else if (cpu_req) begin
                    owner_d      = OWN_CPU;
                    last_grant_d = OWN_CPU;
                    addr_d       = avs_address;
                    wdata_d      = avs_writedata;
                    wren_d       = avs_write;
                    state_d      = S_ACC;
                end
            end
            S_ACC: begin
                if (wren_q) begin
                    complete = 1'b1;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (owner_q == OWN_JTAG) begin
                    mon_d = ram_rdata;
                end else begin
                    rdata_d = ram_rdata;
                end
                complete = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete) begin
            state_d = S_IDLE;
            if (owner_q == OWN_JTAG) begin
                ptr_d  = ptr_q + ADDR_W'(1);
                busy_d = 1'b0;
            end else begin
                cpu_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            jpend_q      <= 1'b0;
            jpend_wr_q   <= 1'b0;
            jpend_data_q <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            owner_q      <= OWN_JTAG;
            last_grant_q <= OWN_CPU;
            addr_q       <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            cpu_done_q   <= 1'b0;
            mon_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            jpend_q      <= jpend_d;
            jpend_wr_q   <= jpend_wr_d;
            jpend_data_q <= jpend_data_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            cpu_done_q   <= cpu_done_d;
            mon_q        <= mon_d;
            rdata_q      <= rdata_d;
        end
    end

    assign MonDReg         = mon_q;
    assign jtag_busy       = busy_q;
    assign jtag_overrun    = overrun_q;
    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = (avs_read | avs_write) & ~cpu_done_q;
    assign ram_en          = (state_q == S_ACC);
    assign ram_wren        = (state_q == S_ACC) & wren_q;
    assign ram_addr        = addr_q;
    assign ram_wdata       = wdata_q;

endmodule

// File: tb/tb_experiment1_nios2_qsys_0_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed scenarios followed by a random run,
// checked against a word-array model of the RAM and the JTAG address pointer.
module tb_experiment1_nios2_qsys_0_ocimem_arbiter;

    logic        clk;
    logic        reset;
    logic        jtag_addr_load;
    logic [7:0]  jtag_addr;
    logic        jtag_rd;
    logic        jtag_wr;
    logic [31:0] jtag_wdata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        ram_en;
    logic        ram_wren;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    experiment1_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .jtag_addr_load  (jtag_addr_load),
        .jtag_addr       (jtag_addr),
        .jtag_rd         (jtag_rd),
        .jtag_wr         (jtag_wr),
        .jtag_wdata      (jtag_wdata),
        .MonDReg         (MonDReg),
        .jtag_busy       (jtag_busy),
        .jtag_overrun    (jtag_overrun),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .ram_en          (ram_en),
        .ram_wren        (ram_wren),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM (1-cycle read latency) plus an access log.
    logic [31:0] ram [256];
    logic [7:0]  last_addr;
    logic [7:0]  acc_log [$];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram_rdata = 32'h0;
        last_addr = 8'h0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wren) ram[ram_addr] <= ram_wdata;
            else          ram_rdata <= ram[ram_addr];
            last_addr <= ram_addr;
            acc_log.push_back(ram_addr);
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_ptr;
    logic        ref_ovr;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic jtag_load(input logic [7:0] a);
        jtag_addr_load = 1'b1;
        jtag_addr      = a;
        tick();
        jtag_addr_load = 1'b0;
        ref_ptr = a;
        ref_ovr = 1'b0;
        chk("load_overrun", 32'(jtag_overrun), 32'(ref_ovr));
        chk("load_busy", 32'(jtag_busy), 32'd0);
    endtask

    task automatic jtag_cmd(input logic ld, input logic [7:0] a, input logic rd,
                            input logic wr, input logic [31:0] d);
        int          lat;
        int          exp_lat;
        logic [7:0]  exp_addr;
        logic [31:0] exp_mon;
        jtag_addr_load = ld;
        jtag_addr      = a;
        jtag_rd        = rd;
        jtag_wr        = wr;
        jtag_wdata     = d;
        if (ld) begin
            ref_ptr = a;
            ref_ovr = 1'b0;
        end
        if (rd && wr) ref_ovr = 1'b1;
        exp_addr = ref_ptr;
        exp_mon  = ref_mem[ref_ptr];
        if (wr) begin
            ref_mem[ref_ptr] = d;
            exp_lat = 3;
        end else begin
            exp_lat = 4;
        end
        ref_ptr = ref_ptr + 8'd1;
        tick();
        jtag_addr_load = 1'b0;
        jtag_rd        = 1'b0;
        jtag_wr        = 1'b0;
        lat = 1;
        while (jtag_busy && lat < 40) begin
            tick();
            lat++;
        end
        $display("jtag %s addr=%02h data=%08h lat=%0d", wr ? "wr" : "rd", exp_addr,
                 wr ? d : MonDReg, lat);
        chk("jtag_latency", 32'(lat), 32'(exp_lat));
        chk("jtag_ram_addr", 32'(last_addr), 32'(exp_addr));
        if (!wr) chk("jtag_MonDReg", MonDReg, exp_mon);
        chk("jtag_overrun", 32'(jtag_overrun), 32'(ref_ovr));
    endtask

    task automatic cpu_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_rd;
        avs_address   = a;
        avs_writedata = d;
        avs_write     = wr;
        avs_read      = ~wr;
        exp_rd = ref_mem[a];
        if (wr) begin
            ref_mem[a] = d;
            exp_lat = 2;
        end else begin
            exp_lat = 3;
        end
        #1;
        lat = 0;
        while (avs_waitrequest && lat < 40) begin
            tick();
            lat++;
        end
        $display("cpu %s addr=%02h data=%08h lat=%0d", wr ? "wr" : "rd", a,
                 wr ? d : avs_readdata, lat);
        chk("cpu_latency", 32'(lat), 32'(exp_lat));
        if (!wr) chk("cpu_readdata", avs_readdata, exp_rd);
        tick();
        avs_write = 1'b0;
        avs_read  = 1'b0;
        chk("cpu_ram_addr", 32'(last_addr), 32'(a));
    endtask

    // JTAG read strobed one cycle before a CPU write so both meet in one idle cycle.
    task automatic tie(input logic jtag_first, input logic [7:0] ja,
                       input logic [7:0] ca, input logic [31:0] cd);
        int          lat;
        int          n;
        logic [31:0] exp_mon;
        acc_log.delete();
        jtag_addr_load = 1'b1;
        jtag_addr      = ja;
        jtag_rd        = 1'b1;
        tick();
        jtag_addr_load = 1'b0;
        jtag_rd        = 1'b0;
        exp_mon = ref_mem[ja];
        ref_ptr = ja + 8'd1;
        ref_ovr = 1'b0;
        ref_mem[ca] = cd;
        avs_write     = 1'b1;
        avs_address   = ca;
        avs_writedata = cd;
        #1;
        lat = 0;
        while (avs_waitrequest && lat < 40) begin
            tick();
            lat++;
        end
        tick();
        avs_write = 1'b0;
        n = 0;
        while (jtag_busy && n < 40) begin
            tick();
            n++;
        end
        $display("tie jtag_first=%0d cpu_lat=%0d order=%02h,%02h", jtag_first, lat,
                 acc_log.size() > 0 ? acc_log[0] : 8'h0, acc_log.size() > 1 ? acc_log[1] : 8'h0);
        chk("tie_cpu_latency", 32'(lat), jtag_first ? 32'd5 : 32'd2);
        chk("tie_jtag_busy", 32'(jtag_busy), 32'd0);
        chk("tie_MonDReg", MonDReg, exp_mon);
        chk("tie_access_count", 32'(acc_log.size()), 32'd2);
        chk("tie_first_addr", 32'(acc_log.size() > 0 ? acc_log[0] : 8'h0),
            32'(jtag_first ? ja : ca));
        chk("tie_ram_write", ram[ca], cd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_ptr = 8'h0;
        ref_ovr = 1'b0;
    endtask

    initial begin
        int          lat;
        int          n;
        int          bad;
        logic [31:0] exp_mon;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_ptr = 8'h0;
        ref_ovr = 1'b0;
        reset = 1'b1;
        jtag_addr_load = 1'b0; jtag_addr = 8'h0; jtag_rd = 1'b0; jtag_wr = 1'b0;
        jtag_wdata = 32'h0;
        avs_address = 8'h20; avs_read = 1'b1; avs_write = 1'b0; avs_writedata = 32'h0;

        // Reset values, with a CPU request held through reset
        tick();
        tick();
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_avs_readdata", avs_readdata, 32'h0);
        chk("rst_jtag_busy", 32'(jtag_busy), 32'd0);
        chk("rst_jtag_overrun", 32'(jtag_overrun), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_wren", 32'(ram_wren), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
        avs_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // JTAG write then read back
        jtag_load(8'h10);
        jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("t1_ram10", ram[8'h10], 32'hDEADBEEF);
        jtag_load(8'h10);
        jtag_cmd(1'b0, 8'h0, 1'b1, 1'b0, 32'h0);
        chk("t1_MonDReg", MonDReg, 32'hDEADBEEF);
        jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, 32'h0000A5A5);
        chk("t1_ptr_11", 32'(last_addr), 32'h11);

        // Address wrap
        jtag_load(8'hFF);
        jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, 32'hAAAA0001);
        jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, 32'hBBBB0002);
        chk("wrap_ramFF", ram[8'hFF], 32'hAAAA0001);
        chk("wrap_ram00", ram[8'h00], 32'hBBBB0002);
        jtag_cmd(1'b0, 8'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap_ptr_01", 32'(last_addr), 32'h01);

        // CPU write/read
        cpu_xfer(1'b1, 8'h20, 32'h12345678);
        cpu_xfer(1'b0, 8'h20, 32'h0);
        chk("cpu_rd_value", avs_readdata, 32'h12345678);

        // Ties: after reset JTAG wins; once JTAG was last granted, CPU wins
        do_reset();
        tie(1'b1, 8'h10, 8'h40, 32'hCAFE0001);
        jtag_cmd(1'b1, 8'h50, 1'b0, 1'b1, 32'h55550050);
        tie(1'b0, 8'h10, 8'h41, 32'hCAFE0002);

        // Reset while a JTAG read sits in ACC, CPU read held across it
        acc_log.delete();
        jtag_addr_load = 1'b1; jtag_addr = 8'h10; jtag_rd = 1'b1;
        tick();
        jtag_addr_load = 1'b0; jtag_rd = 1'b0;
        tick();
        chk("mrst_in_acc", 32'(ram_en), 32'd1);
        avs_read = 1'b1; avs_address = 8'h20; reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_ptr = 8'h0;
        ref_ovr = 1'b0;
        chk("mrst_busy", 32'(jtag_busy), 32'd0);
        chk("mrst_MonDReg", MonDReg, 32'h0);
        chk("mrst_ram_en", 32'(ram_en), 32'd0);
        chk("mrst_waitrequest", 32'(avs_waitrequest), 32'd1);
        lat = 0;
        while (avs_waitrequest && lat < 40) begin
            tick();
            lat++;
        end
        $display("midreset cpu rd addr=20 data=%08h lat=%0d", avs_readdata, lat);
        chk("mrst_cpu_latency", 32'(lat), 32'd3);
        chk("mrst_cpu_readdata", avs_readdata, ref_mem[8'h20]);
        tick();
        avs_read = 1'b0;
        chk("mrst_ram10_intact", ram[8'h10], ref_mem[8'h10]);
        jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, 32'h0F0F0F0F);
        chk("mrst_ptr_zero", 32'(last_addr), 32'h0);

        // Overrun: write strobe while a read is in flight
        acc_log.delete();
        jtag_addr_load = 1'b1; jtag_addr = 8'h60; jtag_rd = 1'b1;
        tick();
        jtag_addr_load = 1'b0; jtag_rd = 1'b0;
        jtag_wr = 1'b1; jtag_wdata = 32'h0BAD0BAD;
        tick();
        jtag_wr = 1'b0;
        exp_mon = ref_mem[8'h60];
        ref_ptr = 8'h61;
        ref_ovr = 1'b1;
        chk("ovr_set", 32'(jtag_overrun), 32'd1);
        n = 0;
        while (jtag_busy && n < 40) begin
            tick();
            n++;
        end
        $display("overrun rd addr=60 data=%08h accesses=%0d", MonDReg, acc_log.size());
        chk("ovr_MonDReg", MonDReg, exp_mon);
        chk("ovr_access_count", 32'(acc_log.size()), 32'd1);
        chk("ovr_ram61_intact", ram[8'h61], ref_mem[8'h61]);
        chk("ovr_sticky", 32'(jtag_overrun), 32'd1);
        jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, 32'h600D600D);
        jtag_cmd(1'b1, 8'h62, 1'b1, 1'b1, 32'h77777777);
        chk("ovr_rdwr_write", ram[8'h62], 32'h77777777);
        jtag_load(8'h70);

        // Random serialized traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: jtag_cmd(1'b1, 8'($urandom), 1'b0, 1'b1, $urandom);
                1: jtag_cmd(1'b0, 8'h0, 1'b0, 1'b1, $urandom);
                2: jtag_cmd(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0, 32'h0);
                3: cpu_xfer(1'b1, 8'($urandom), $urandom);
                4: cpu_xfer(1'b0, 8'($urandom), 32'h0);
                default: jtag_load(8'($urandom));
            endcase
        end

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== ref_mem[i]) bad++;
        end
        chk("ram_contents_mismatches", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
